// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
// The stimulus side takes the master modport and the counter takes the slave modport.
interface mod_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             sat_mode;
  logic             ovf_clr;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap_pulse;
  logic             ovf_sticky;

  modport master (
    output en, up, load, load_val, sat_mode, ovf_clr,
    input  count, tc, wrap_pulse, ovf_sticky
  );

  modport slave (
    input  en, up, load, load_val, sat_mode, ovf_clr,
    output count, tc, wrap_pulse, ovf_sticky
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load, wrap or saturate, terminal count and a sticky overflow flag.
// Optional prescaler: define COUNTER_PRESCALE_EN to take one step every PRESCALE enabled cycles.
module mod_updown_counter #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  mod_updown_counter_if.slave   bus
);

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 1..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $error("mod_updown_counter: PRESCALE must be in 1..256");
  end

  // One extra bit keeps MODULUS itself representable when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_max;
  logic             at_min;
  logic             ld_in_range;

  assign at_max      = {1'b0, count_q} == MAX_EXT;
  assign at_min      = count_q == '0;
  assign ld_in_range = {1'b0, bus.load_val} < MOD_EXT;

`ifdef COUNTER_PRESCALE_EN
  localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q;
  logic            ps_hit;

  assign ps_hit = ps_q == PS_LAST;
  assign step   = bus.en && ps_hit;

  always_ff @(posedge clk) begin
    if (clr || bus.load) begin
      ps_q <= '0;
    end else if (bus.en) begin
      ps_q <= ps_hit ? '0 : ps_q + PS_W'(1);
    end
  end
`else
  assign step = bus.en;
`endif

  // NOTE: every output of this block gets a default before any branch, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q && !bus.ovf_clr;

    if (bus.load) begin
      count_d = ld_in_range ? bus.load_val : MAX_CNT;
    end else if (step) begin
      if (bus.up) begin
        if (!at_max) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          // Boundary event: set beats a coincident ovf_clr.
          ovf_d = 1'b1;
          if (!bus.sat_mode) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end
      end else begin
        if (!at_min) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          ovf_d = 1'b1;
          if (!bus.sat_mode) begin
            count_d = MAX_CNT;
            wrap_d  = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.tc         = (bus.up && at_max) || (!bus.up && at_min);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter: table-driven vectors on a MODULUS=6 instance,
// plus hand sequences for full-range MODULUS=8 and, when COUNTER_PRESCALE_EN is defined, PRESCALE=3.
module tb_mod_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic clr6, clr8;
  mod_updown_counter_if #(.WIDTH(3)) bus6 ();
  mod_updown_counter_if #(.WIDTH(3)) bus8 ();

  mod_updown_counter #(.WIDTH(3), .MODULUS(6), .PRESCALE(1)) dut6 (
    .clk (clk),
    .clr (clr6),
    .bus (bus6)
  );

  mod_updown_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(1)) dut8 (
    .clk (clk),
    .clr (clr8),
    .bus (bus8)
  );

`ifdef COUNTER_PRESCALE_EN
  logic clr_ps;
  mod_updown_counter_if #(.WIDTH(3)) bus_ps ();
  mod_updown_counter #(.WIDTH(3), .MODULUS(6), .PRESCALE(3)) dut_ps (
    .clk (clk),
    .clr (clr_ps),
    .bus (bus_ps)
  );
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic       clr, en, up, load;
    logic [2:0] load_val;
    logic       sat, oclr;
    logic [2:0] e_count;
    logic       e_tc, e_wrap, e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string n, input logic c, e, u, l, input logic [2:0] lv,
                              input logic s, o, input logic [2:0] ec, input logic et, ew, eo);
    vec_t v;
    v.name = n; v.clr = c; v.en = e; v.up = u; v.load = l; v.load_val = lv;
    v.sat = s; v.oclr = o; v.e_count = ec; v.e_tc = et; v.e_wrap = ew; v.e_ovf = eo;
    vecs.push_back(v);
  endfunction

  task automatic apply6(input vec_t v);
    @(negedge clk);
    clr6          = v.clr;
    bus6.en       = v.en;
    bus6.up       = v.up;
    bus6.load     = v.load;
    bus6.load_val = v.load_val;
    bus6.sat_mode = v.sat;
    bus6.ovf_clr  = v.oclr;
    @(posedge clk);
    #1;
    check({v.name, ".count"}, 32'(bus6.count), 32'(v.e_count));
    check({v.name, ".tc"},    32'(bus6.tc), 32'(v.e_tc));
    check({v.name, ".wrap"},  32'(bus6.wrap_pulse), 32'(v.e_wrap));
    check({v.name, ".ovf"},   32'(bus6.ovf_sticky), 32'(v.e_ovf));
  endtask

  task automatic drive8(input logic c, e, u, l, input logic [2:0] lv);
    @(negedge clk);
    clr8 = c; bus8.en = e; bus8.up = u; bus8.load = l; bus8.load_val = lv;
    @(posedge clk);
    #1;
  endtask

`ifdef COUNTER_PRESCALE_EN
  task automatic drive_ps(input logic c, e);
    @(negedge clk);
    clr_ps = c; bus_ps.en = e;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp8;

    clr6 = 1'b1; clr8 = 1'b1;
    bus6.en = 0; bus6.up = 0; bus6.load = 0; bus6.load_val = '0; bus6.sat_mode = 0; bus6.ovf_clr = 0;
    bus8.en = 0; bus8.up = 0; bus8.load = 0; bus8.load_val = '0; bus8.sat_mode = 0; bus8.ovf_clr = 0;
`ifdef COUNTER_PRESCALE_EN
    clr_ps = 1'b1;
    bus_ps.en = 0; bus_ps.up = 1; bus_ps.load = 0; bus_ps.load_val = '0;
    bus_ps.sat_mode = 0; bus_ps.ovf_clr = 0;
`endif

    //   name          clr en up ld  lv  sat oc  cnt tc wr ov
    add("rst0",        1, 0, 0, 0, 3'd0, 0, 0, 3'd0, 1, 0, 0);
    add("ld4",         0, 0, 1, 1, 3'd4, 0, 0, 3'd4, 0, 0, 0);
    add("rst1",        1, 0, 1, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0);
    add("rst2",        1, 0, 0, 0, 3'd0, 0, 0, 3'd0, 1, 0, 0);
    add("up1",         0, 1, 1, 0, 3'd0, 0, 0, 3'd1, 0, 0, 0);
    add("up2",         0, 1, 1, 0, 3'd0, 0, 0, 3'd2, 0, 0, 0);
    add("up3",         0, 1, 1, 0, 3'd0, 0, 0, 3'd3, 0, 0, 0);
    add("up4",         0, 1, 1, 0, 3'd0, 0, 0, 3'd4, 0, 0, 0);
    add("up5",         0, 1, 1, 0, 3'd0, 0, 0, 3'd5, 1, 0, 0);
    add("up_wrap",     0, 1, 1, 0, 3'd0, 0, 0, 3'd0, 0, 1, 1);
    add("up7",         0, 1, 1, 0, 3'd0, 0, 0, 3'd1, 0, 0, 1);
    add("hold",        0, 0, 1, 0, 3'd0, 0, 0, 3'd1, 0, 0, 1);
    add("oclr",        0, 0, 0, 0, 3'd0, 0, 1, 3'd1, 0, 0, 0);
    add("ld1",         0, 0, 0, 1, 3'd1, 0, 0, 3'd1, 0, 0, 0);
    add("dn1",         0, 1, 0, 0, 3'd0, 1, 0, 3'd0, 1, 0, 0);
    add("dsat1",       0, 1, 0, 0, 3'd0, 1, 0, 3'd0, 1, 0, 1);
    add("dsat2",       0, 1, 0, 0, 3'd0, 1, 0, 3'd0, 1, 0, 1);
    add("dwrap",       0, 1, 0, 0, 3'd0, 0, 0, 3'd5, 0, 1, 1);
    add("ld_kill_wrap",0, 1, 0, 1, 3'd2, 0, 0, 3'd2, 0, 0, 1);
    add("clamp",       0, 1, 1, 1, 3'd7, 0, 0, 3'd5, 1, 0, 1);
    add("usat",        0, 1, 1, 0, 3'd0, 1, 0, 3'd5, 1, 0, 1);
    add("clr_ld",      1, 1, 1, 1, 3'd3, 0, 0, 3'd0, 0, 0, 0);
    add("ld5",         0, 0, 1, 1, 3'd5, 0, 0, 3'd5, 1, 0, 0);
    add("wrap_oclr",   0, 1, 1, 0, 3'd0, 0, 1, 3'd0, 0, 1, 1);
    add("oclr_alone",  0, 0, 1, 0, 3'd0, 0, 1, 3'd0, 0, 0, 0);
    add("dir_dn",      0, 1, 0, 0, 3'd0, 0, 0, 3'd5, 0, 1, 1);
    add("dir_up",      0, 1, 1, 0, 3'd0, 0, 0, 3'd0, 0, 1, 1);
    add("idle",        0, 0, 1, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) apply6(vecs[i]);
    @(negedge clk);
    bus6.en = 0; bus6.load = 0; bus6.ovf_clr = 0;

    // Full-range modulus: 7 -> 0 must wrap, and the count must stay in 0..7.
    drive8(1, 0, 1, 0, 3'd0);
    check("m8_rst", 32'(bus8.count), 32'd0);
    drive8(0, 0, 1, 1, 3'd7);
    check("m8_ld7", 32'(bus8.count), 32'd7);
    check("m8_tc7", 32'(bus8.tc), 32'd1);
    drive8(0, 1, 1, 0, 3'd0);
    check("m8_wrap_cnt", 32'(bus8.count), 32'd0);
    check("m8_wrap_pulse", 32'(bus8.wrap_pulse), 32'd1);
    check("m8_ovf", 32'(bus8.ovf_sticky), 32'd1);
    exp8 = 3'd0;
    for (int i = 0; i < 10; i++) begin
      drive8(0, 1, 1, 0, 3'd0);
      exp8 = 3'((32'(exp8) + 1) % 8);
      check("m8_step", 32'(bus8.count), 32'(exp8));
      check("m8_wrap", 32'(bus8.wrap_pulse), 32'(exp8 == 3'd0));
    end
    drive8(0, 0, 0, 1, 3'd0);
    drive8(0, 1, 0, 0, 3'd0);
    check("m8_dwrap", 32'(bus8.count), 32'd7);

`ifdef COUNTER_PRESCALE_EN
    drive_ps(1, 0);
    check("ps_rst", 32'(bus_ps.count), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      drive_ps(0, 1);
      check("ps_run", 32'(bus_ps.count), 32'(i / 3));
    end
    drive_ps(0, 1);
    check("ps_pre_hold", 32'(bus_ps.count), 32'd3);
    drive_ps(0, 0);
    check("ps_hold1", 32'(bus_ps.count), 32'd3);
    drive_ps(0, 0);
    check("ps_hold2", 32'(bus_ps.count), 32'd3);
    drive_ps(0, 1);
    check("ps_delayed", 32'(bus_ps.count), 32'd3);
    drive_ps(0, 1);
    check("ps_step4", 32'(bus_ps.count), 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
